// File: rtl/tcp_flowid_free_list_if.sv
// Bundle of signals between the TCP flow-ID free list and its users, which are
// the new-flow controller and the teardown path.
//   master: drives flowid_manager_req, flowid_ret_val and flowid_ret_id.
//   slave : the free list. It drives flowid_avail, flowid_alloc, flowid_ret_rdy,
//           free_count, init_done and flowid_dup_err.
interface tcp_flowid_free_list_if #(
  parameter int unsigned FLOWID_W = 3
);
  logic                flowid_manager_req;
  logic                flowid_avail;
  logic [FLOWID_W-1:0] flowid_alloc;
  logic                flowid_ret_val;
  logic [FLOWID_W-1:0] flowid_ret_id;
  logic                flowid_ret_rdy;
  logic [FLOWID_W:0]   free_count;
  logic                init_done;
  logic                flowid_dup_err;

  modport master (
    output flowid_manager_req, flowid_ret_val, flowid_ret_id,
    input  flowid_avail, flowid_alloc, flowid_ret_rdy, free_count, init_done, flowid_dup_err
  );

  modport slave (
    input  flowid_manager_req, flowid_ret_val, flowid_ret_id,
    output flowid_avail, flowid_alloc, flowid_ret_rdy, free_count, init_done, flowid_dup_err
  );
endinterface

// File: rtl/tcp_flowid_free_list.sv
// Free-list manager for TCP flow IDs on the slow path.
// After reset, the list fills itself with IDs 0..NUM_FLOWS-1, writing one entry per cycle.
// It then hands IDs out in FIFO order and takes IDs back from teardown.
// An ID returned while it is not allocated is dropped, and it sets a sticky error flag.
// Ports:
//   clk, rst : clock and synchronous active-high reset.
//   bus      : slave side of tcp_flowid_free_list_if. It carries alloc/req,
//              return, count, init and error signals.
module tcp_flowid_free_list #(
  parameter int unsigned FLOWID_W = 3
) (
  input logic                    clk,
  input logic                    rst,
  tcp_flowid_free_list_if.slave  bus
);

  localparam int unsigned NUM_FLOWS = 2 ** FLOWID_W;

  typedef logic [FLOWID_W-1:0] id_t;
  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  id_t                 init_cnt_q, init_cnt_d;
  id_t                 rd_ptr_q, rd_ptr_d;
  id_t                 wr_ptr_q, wr_ptr_d;
  logic [FLOWID_W:0]   free_count_q, free_count_d;
  logic [NUM_FLOWS-1:0] in_use_q, in_use_d;
  logic                dup_err_q, dup_err_d;

  id_t mem_q [NUM_FLOWS];

  logic mem_we;
  id_t  mem_waddr;
  id_t  mem_wdata;

  logic run;
  logic pop;
  logic ret;
  logic ret_ok;

  assign run = (state_q == StRun);
  assign pop = run & bus.flowid_manager_req & (free_count_q != '0);
  assign ret = run & bus.flowid_ret_val;
  // The bitmap is checked before this cycle's pop is applied. A return of the
  // ID being popped right now therefore sees its bit as 0 and counts as an error.
  assign ret_ok = ret & in_use_q[bus.flowid_ret_id];

  assign bus.flowid_avail   = run & (free_count_q != '0);
  assign bus.flowid_alloc   = mem_q[rd_ptr_q];
  assign bus.flowid_ret_rdy = run;
  assign bus.free_count     = free_count_q;
  assign bus.init_done      = run;
  assign bus.flowid_dup_err = dup_err_q;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    free_count_d = free_count_q;
    in_use_d     = in_use_q;
    dup_err_d    = dup_err_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr_q;
    mem_wdata    = bus.flowid_ret_id;

    unique case (state_q)
      StInit: begin
        mem_we       = 1'b1;
        mem_waddr    = init_cnt_q;
        mem_wdata    = init_cnt_q;
        init_cnt_d   = init_cnt_q + 1'b1;
        free_count_d = free_count_q + 1'b1;
        if (init_cnt_q == id_t'(NUM_FLOWS - 1)) begin
          state_d  = StRun;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
        end
      end
      StRun: begin
        if (pop) begin
          rd_ptr_d                   = rd_ptr_q + 1'b1;
          in_use_d[bus.flowid_alloc] = 1'b1;
        end
        if (ret_ok) begin
          mem_we                      = 1'b1;
          wr_ptr_d                    = wr_ptr_q + 1'b1;
          in_use_d[bus.flowid_ret_id] = 1'b0;
        end
        if (ret && !ret_ok) begin
          dup_err_d = 1'b1;
        end
        // When a pop and an accepted return happen in the same cycle, they cancel out.
        unique case ({pop, ret_ok})
          2'b10:   free_count_d = free_count_q - 1'b1;
          2'b01:   free_count_d = free_count_q + 1'b1;
          default: free_count_d = free_count_q;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit;
      init_cnt_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      free_count_q <= '0;
      in_use_q     <= '0;
      dup_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      free_count_q <= free_count_d;
      in_use_q     <= in_use_d;
      dup_err_q    <= dup_err_d;
    end
  end

  // Storage needs no reset, because the init fill rewrites every entry.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_tcp_flowid_free_list.sv
// Directed testbench for tcp_flowid_free_list with FLOWID_W=3 (8 flows).
module tb_tcp_flowid_free_list;

  localparam int unsigned FLOWID_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tcp_flowid_free_list_if #(.FLOWID_W(FLOWID_W)) bus ();

  tcp_flowid_free_list #(.FLOWID_W(FLOWID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flowid_manager_req = 1'b0;
    bus.flowid_ret_val = 1'b0;
    bus.flowid_ret_id = '0;
    tick();
    tick();
    checks++; if (bus.flowid_avail !== 1'b0) begin errors++; $display("FAIL reset_avail: got %0b want 0", bus.flowid_avail); end
    checks++; if (bus.flowid_ret_rdy !== 1'b0) begin errors++; $display("FAIL reset_ret_rdy: got %0b want 0", bus.flowid_ret_rdy); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %0b want 0", bus.init_done); end
    checks++; if (bus.free_count !== 4'd0) begin errors++; $display("FAIL reset_free_count: got %0d want 0", bus.free_count); end
    checks++; if (bus.flowid_dup_err !== 1'b0) begin errors++; $display("FAIL reset_dup_err: got %0b want 0", bus.flowid_dup_err); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.flowid_avail !== 1'b0) begin errors++; $display("FAIL init_avail_low[%0d]: got %0b want 0", i, bus.flowid_avail); end
      tick();
    end
    checks++; if (bus.flowid_avail !== 1'b1) begin errors++; $display("FAIL init_avail: got %0b want 1", bus.flowid_avail); end
    checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %0b want 1", bus.init_done); end
    checks++; if (bus.flowid_ret_rdy !== 1'b1) begin errors++; $display("FAIL init_ret_rdy: got %0b want 1", bus.flowid_ret_rdy); end
    checks++; if (bus.free_count !== 4'd8) begin errors++; $display("FAIL init_free_count: got %0d want 8", bus.free_count); end
    checks++; if (bus.flowid_alloc !== 3'd0) begin errors++; $display("FAIL init_alloc: got %0d want 0", bus.flowid_alloc); end
  endtask

  task automatic test_reset_mid_run();
    bus.flowid_manager_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.flowid_alloc !== FLOWID_W'(i)) begin errors++; $display("FAIL midrun_alloc[%0d]: got %0d want %0d", i, bus.flowid_alloc, i); end
      tick();
    end
    bus.flowid_manager_req = 1'b0;
    checks++; if (bus.free_count !== 4'd5) begin errors++; $display("FAIL midrun_count: got %0d want 5", bus.free_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.free_count !== 4'd0) begin errors++; $display("FAIL midrun_rst_count: got %0d want 0", bus.free_count); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL midrun_rst_init_done: got %0b want 0", bus.init_done); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.flowid_avail !== 1'b0) begin errors++; $display("FAIL midrun_init_avail_low[%0d]: got %0b want 0", i, bus.flowid_avail); end
      tick();
    end
    checks++; if (bus.flowid_avail !== 1'b1) begin errors++; $display("FAIL midrun_reinit_avail: got %0b want 1", bus.flowid_avail); end
    checks++; if (bus.free_count !== 4'd8) begin errors++; $display("FAIL midrun_reinit_count: got %0d want 8", bus.free_count); end
    checks++; if (bus.flowid_alloc !== 3'd0) begin errors++; $display("FAIL midrun_reinit_alloc: got %0d want 0", bus.flowid_alloc); end
    checks++; if (bus.flowid_dup_err !== 1'b0) begin errors++; $display("FAIL midrun_reinit_dup: got %0b want 0", bus.flowid_dup_err); end
  endtask

  task automatic test_drain();
    bus.flowid_manager_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.flowid_avail !== 1'b1) begin errors++; $display("FAIL drain_avail[%0d]: got %0b want 1", i, bus.flowid_avail); end
      checks++; if (bus.flowid_alloc !== FLOWID_W'(i)) begin errors++; $display("FAIL drain_alloc[%0d]: got %0d want %0d", i, bus.flowid_alloc, i); end
      tick();
    end
    checks++; if (bus.flowid_avail !== 1'b0) begin errors++; $display("FAIL drain_empty_avail: got %0b want 0", bus.flowid_avail); end
    checks++; if (bus.free_count !== 4'd0) begin errors++; $display("FAIL drain_empty_count: got %0d want 0", bus.free_count); end
    tick();
    checks++; if (bus.free_count !== 4'd0) begin errors++; $display("FAIL drain_extra_req_count: got %0d want 0", bus.free_count); end
    checks++; if (bus.flowid_avail !== 1'b0) begin errors++; $display("FAIL drain_extra_req_avail: got %0b want 0", bus.flowid_avail); end
    bus.flowid_manager_req = 1'b0;
  endtask

  task automatic test_refill();
    logic [FLOWID_W-1:0] exp_ids [3];
    exp_ids[0] = 3'd5; exp_ids[1] = 3'd2; exp_ids[2] = 3'd7;
    // The list is empty, so the req in this cycle must be ignored.
    bus.flowid_manager_req = 1'b1;
    bus.flowid_ret_val = 1'b1;
    bus.flowid_ret_id = 3'd5;
    tick();
    bus.flowid_manager_req = 1'b0;
    checks++; if (bus.flowid_avail !== 1'b1) begin errors++; $display("FAIL refill_avail: got %0b want 1", bus.flowid_avail); end
    checks++; if (bus.free_count !== 4'd1) begin errors++; $display("FAIL refill_first_count: got %0d want 1", bus.free_count); end
    checks++; if (bus.flowid_alloc !== 3'd5) begin errors++; $display("FAIL refill_head: got %0d want 5", bus.flowid_alloc); end
    bus.flowid_ret_id = 3'd2;
    tick();
    bus.flowid_ret_id = 3'd7;
    tick();
    bus.flowid_ret_val = 1'b0;
    checks++; if (bus.free_count !== 4'd3) begin errors++; $display("FAIL refill_count: got %0d want 3", bus.free_count); end
    bus.flowid_manager_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.flowid_alloc !== exp_ids[i]) begin errors++; $display("FAIL refill_order[%0d]: got %0d want %0d", i, bus.flowid_alloc, exp_ids[i]); end
      tick();
    end
    bus.flowid_manager_req = 1'b0;
    checks++; if (bus.free_count !== 4'd0) begin errors++; $display("FAIL refill_drained_count: got %0d want 0", bus.free_count); end
    checks++; if (bus.flowid_dup_err !== 1'b0) begin errors++; $display("FAIL refill_dup: got %0b want 0", bus.flowid_dup_err); end
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    bus.flowid_manager_req = 1'b1;
    repeat (4) tick();
    checks++; if (bus.free_count !== 4'd4) begin errors++; $display("FAIL simul_pre_count: got %0d want 4", bus.free_count); end
    checks++; if (bus.flowid_alloc !== 3'd4) begin errors++; $display("FAIL simul_pre_head: got %0d want 4", bus.flowid_alloc); end
    bus.flowid_ret_val = 1'b1;
    bus.flowid_ret_id = 3'd1;
    tick();
    bus.flowid_manager_req = 1'b0;
    bus.flowid_ret_val = 1'b0;
    checks++; if (bus.free_count !== 4'd4) begin errors++; $display("FAIL simul_count: got %0d want 4", bus.free_count); end
    checks++; if (bus.flowid_alloc !== 3'd5) begin errors++; $display("FAIL simul_head: got %0d want 5", bus.flowid_alloc); end
    checks++; if (bus.flowid_dup_err !== 1'b0) begin errors++; $display("FAIL simul_dup: got %0b want 0", bus.flowid_dup_err); end
  endtask

  // This test continues from the simultaneous test: the free list holds 5, 6, 7, 1.
  task automatic test_duplicate();
    logic [FLOWID_W-1:0] exp_ids [4];
    exp_ids[0] = 3'd5; exp_ids[1] = 3'd6; exp_ids[2] = 3'd7; exp_ids[3] = 3'd1;
    bus.flowid_ret_val = 1'b1;
    bus.flowid_ret_id = 3'd6;
    checks++; if (bus.flowid_dup_err !== 1'b0) begin errors++; $display("FAIL dup_before: got %0b want 0", bus.flowid_dup_err); end
    tick();
    bus.flowid_ret_val = 1'b0;
    checks++; if (bus.flowid_dup_err !== 1'b1) begin errors++; $display("FAIL dup_set: got %0b want 1", bus.flowid_dup_err); end
    checks++; if (bus.free_count !== 4'd4) begin errors++; $display("FAIL dup_count: got %0d want 4", bus.free_count); end
    repeat (3) tick();
    checks++; if (bus.flowid_dup_err !== 1'b1) begin errors++; $display("FAIL dup_sticky: got %0b want 1", bus.flowid_dup_err); end
    bus.flowid_manager_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.flowid_alloc !== exp_ids[i]) begin errors++; $display("FAIL dup_order[%0d]: got %0d want %0d", i, bus.flowid_alloc, exp_ids[i]); end
      tick();
    end
    bus.flowid_manager_req = 1'b0;
    checks++; if (bus.flowid_avail !== 1'b0) begin errors++; $display("FAIL dup_drained_avail: got %0b want 0", bus.flowid_avail); end
    checks++; if (bus.flowid_dup_err !== 1'b1) begin errors++; $display("FAIL dup_sticky_end: got %0b want 1", bus.flowid_dup_err); end
  endtask

  // This test returns the ID in the same cycle that the ID is popped.
  // The return is judged against the pre-cycle bitmap and is therefore an error.
  task automatic test_collision();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    bus.flowid_manager_req = 1'b1;
    bus.flowid_ret_val = 1'b1;
    bus.flowid_ret_id = 3'd0;
    tick();
    bus.flowid_manager_req = 1'b0;
    bus.flowid_ret_val = 1'b0;
    checks++; if (bus.flowid_dup_err !== 1'b1) begin errors++; $display("FAIL collide_dup: got %0b want 1", bus.flowid_dup_err); end
    checks++; if (bus.free_count !== 4'd7) begin errors++; $display("FAIL collide_count: got %0d want 7", bus.free_count); end
    checks++; if (bus.flowid_alloc !== 3'd1) begin errors++; $display("FAIL collide_head: got %0d want 1", bus.flowid_alloc); end
    bus.flowid_ret_val = 1'b1;
    bus.flowid_ret_id = 3'd0;
    tick();
    bus.flowid_ret_val = 1'b0;
    checks++; if (bus.free_count !== 4'd8) begin errors++; $display("FAIL collide_legal_ret_count: got %0d want 8", bus.free_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_run();
    test_drain();
    test_refill();
    test_simultaneous();
    test_duplicate();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_flowid_free_list.md
# tcp_flowid_free_list

Free-list manager for TCP flow IDs on the slow path. It hands out unused flow IDs to the new-flow control FSM on `flowid_manager_req`. It takes IDs back from the flow-teardown path. It flags any duplicate or illegal return. The block sits directly beside the new-flow controller: its `flowid_avail`/`flowid_alloc` outputs gate SYN acceptance, and the allocated ID is what the controller latches with `slow_path_store_flowid`.

## Interface
- `FLOWID_W`, default 3: flow ID width. Number of flows is `NUM_FLOWS = 2**FLOWID_W`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset. Sampled on `posedge clk`.
- `flowid_manager_req`  in  1  pop the head ID. Honoured only when `flowid_avail=1`; ignored otherwise.
- `flowid_avail`  out  1  free list is non-empty and initialisation is complete.
- `flowid_alloc`  out  FLOWID_W  head-of-list ID. Valid only while `flowid_avail=1`.
- `flowid_ret_val`  in  1  an ID is being returned.
- `flowid_ret_id`  in  FLOWID_W  the ID being returned.
- `flowid_ret_rdy`  out  1  return accepted this cycle. High whenever `init_done=1`.
- `free_count`  out  FLOWID_W+1  number of IDs currently in the free list.
- `init_done`  out  1  the initial fill has finished.
- `flowid_dup_err`  out  1  sticky flag: an ID was returned that was not allocated. Cleared only by `rst`.

## Operation
- Storage:
  - FIFO of NUM_FLOWS entries × FLOWID_W bits, built from flops.
  - `rd_ptr` and `wr_ptr` are FLOWID_W bits wide and wrap modulo NUM_FLOWS.
  - `free_count` is tracked separately, so full and empty are never ambiguous.
- In-use bitmap: NUM_FLOWS bits, where bit i = 1 means ID i is currently allocated.
- State machine, states INIT and RUN:
  - INIT, entered on `rst`:
    - Each cycle, write `init_cnt` to `mem[init_cnt]`, then increment `init_cnt` and `free_count`.
    - When `init_cnt == NUM_FLOWS-1` has been written, go to RUN with `wr_ptr = 0` (wrapped) and `rd_ptr = 0`.
    - `flowid_manager_req` and `flowid_ret_val` are ignored in INIT.
  - RUN:
    - `init_done=1`.
    - `flowid_avail = (free_count != 0)`.
    - `flowid_alloc = mem[rd_ptr]`, driven combinationally.
- Pop: on a cycle with `flowid_manager_req & flowid_avail`:
  - `rd_ptr` increments.
  - `free_count` decrements.
  - The bitmap bit for `flowid_alloc` is set.
- Return: on a cycle with `flowid_ret_val & flowid_ret_rdy`:
  - If the bitmap bit for `flowid_ret_id` is 1: write the ID to `mem[wr_ptr]`, increment `wr_ptr`, increment `free_count`, and clear the bitmap bit.
  - If the bit is 0: drop the return, leave pointers and count unchanged, and set `flowid_dup_err`.
- Pop and return in the same cycle:
  - Both take effect and `free_count` is unchanged.
  - If the returned ID equals the ID being popped, the pop sets its bitmap bit and the return is judged against the pre-cycle bitmap, i.e. 0. The return is therefore an error.
- Empty list with a return: the pop is ignored that cycle because `avail=0`. The returned ID is at the head next cycle.
- Full list: cannot overflow, because every accepted return corresponds to an allocated ID. `free_count` never exceeds NUM_FLOWS.
- Allocation order is strict FIFO:
  - IDs 0, 1, …, NUM_FLOWS-1 after reset.
  - After that, IDs come out in the order they were returned.

## Timing
- Reset values:
  - `flowid_avail=0`, `flowid_ret_rdy=0`, `init_done=0`, `free_count=0`, `flowid_dup_err=0`.
  - Bitmap all 0; `rd_ptr`, `wr_ptr` and `init_cnt` all 0.
  - `flowid_alloc` is don't-care.
- Init length: with `rst` deasserted before edge 0, the entry for ID 0 is written at edge 0. `init_done`, `flowid_avail` and `flowid_ret_rdy` rise after edge NUM_FLOWS-1, with `free_count = NUM_FLOWS`.
- Pop latency: 0 cycles. `flowid_alloc` is valid in the same cycle as `req`. The next ID appears after the clock edge.
- Return latency: an ID accepted at edge k is allocatable from the cycle after edge k. If the list was empty, `flowid_avail` rises 1 cycle after acceptance.
- `flowid_dup_err` rises the cycle after the offending return.
- Reset mid-operation: all outstanding allocations are forgotten, the block re-enters INIT, and the list is refilled with 0..NUM_FLOWS-1.

## Test plan
- Init: release `rst` and hold `req=0`. Expect `avail=0` for 8 cycles (FLOWID_W=3), then `avail=1`, `free_count=8`, `flowid_alloc=0`.
- Drain: hold `req=1` after init. Expect `flowid_alloc` = 0,1,…,7 on consecutive cycles, then `avail=0` and `free_count=0`; a further `req` changes nothing.
- Refill order: allocate all 8 IDs, then return 5, 2, 7. Expect `free_count=3`, and subsequent pops yield 5, 2, 7.
- Simultaneous: allocate 0..3, then in one cycle set `req=1` (head 4) and return 1. Expect `free_count` unchanged at 4, `flowid_alloc=5` next cycle, and ID 1 at the tail.
- Duplicate: return ID 6 while it is still free. Expect `flowid_dup_err=1` next cycle, `free_count` unchanged, and the flag stays set until `rst`.
- Reset mid-run: allocate 3 IDs, assert `rst` for 1 cycle. Expect init to repeat (8 cycles), `free_count=8`, `flowid_alloc=0`, `flowid_dup_err=0`.
